// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I decode constants: opcodes, WBSel encodings and control-word layout.
// Used by control_logic, the ID/EX register and the EX stage.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // d_ctrl = {RegWEn,BrUn,ASel,BSel,ALUSel[3:0],access_size[1:0],DMEM_RW,WBSel[1:0],3'b0}
  localparam int CTRL_W         = 16;
  localparam int CTRL_REGWEN    = 15;
  localparam int CTRL_BRUN      = 14;
  localparam int CTRL_ASEL      = 13;
  localparam int CTRL_BSEL      = 12;
  localparam int CTRL_ALUSEL_LO = 8;
  localparam int CTRL_SIZE_LO   = 6;
  localparam int CTRL_DMEM_RW   = 5;
  localparam int CTRL_WBSEL_LO  = 3;

  // No register write, no memory write, every other field zero.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard check between the instruction in decode and the one held in EX.
// Decided purely by opcode so an unknown opcode is never mistaken for a load.
module id_ex_hazard_detect
  import rv_ctrl_pkg::*;
(
  input  logic       e_valid,
  input  logic [6:0] e_opcode,
  input  logic [4:0] e_rd,
  input  logic [6:0] d_opcode,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  output logic       load_use
);

  logic rs1_used;
  logic rs2_used;

  always_comb begin
    rs1_used = !(d_opcode == OP_LUI || d_opcode == OP_AUIPC || d_opcode == OP_JAL);
    rs2_used = (d_opcode == OP_R) || (d_opcode == OP_STORE) || (d_opcode == OP_BRANCH);
    load_use = e_valid && (e_opcode == OP_LOAD) && (e_rd != 5'd0) &&
               ((rs1_used && (d_rs1 == e_rd)) || (rs2_used && (d_rs2 == e_rd)));
  end

endmodule

// File: rtl/id_ex_pipeline.sv
// Decode->execute pipeline register with load-use bubble insertion, flush squash,
// back-pressure hold and a saturating bubble counter.
module id_ex_pipeline
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  d_pc,
  input  logic [6:0]       d_opcode,
  input  logic [4:0]       d_rd,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic [2:0]       d_funct3,
  input  logic [XLEN-1:0]  d_rs1_data,
  input  logic [XLEN-1:0]  d_rs2_data,
  input  logic [XLEN-1:0]  d_imm,
  input  logic [15:0]      d_ctrl,
  input  logic             flush,
  input  logic             hold,
  output logic             stall_fd,
  output logic             e_valid,
  output logic [XLEN-1:0]  e_pc,
  output logic [XLEN-1:0]  e_rs1_data,
  output logic [XLEN-1:0]  e_rs2_data,
  output logic [XLEN-1:0]  e_imm,
  output logic [6:0]       e_opcode,
  output logic [4:0]       e_rd,
  output logic [4:0]       e_rs1,
  output logic [4:0]       e_rs2,
  output logic [2:0]       e_funct3,
  output logic [15:0]      e_ctrl,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic load_use;

  id_ex_hazard_detect u_hazard (
    .e_valid  (e_valid),
    .e_opcode (e_opcode),
    .e_rd     (e_rd),
    .d_opcode (d_opcode),
    .d_rs1    (d_rs1),
    .d_rs2    (d_rs2),
    .load_use (load_use)
  );

  // A flush redirects fetch, so the decode instruction must not be held even if it hazards.
  assign stall_fd = hold | (load_use & ~flush);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_valid      <= 1'b0;
      e_pc         <= '0;
      e_rs1_data   <= '0;
      e_rs2_data   <= '0;
      e_imm        <= '0;
      e_opcode     <= '0;
      e_rd         <= '0;
      e_rs1        <= '0;
      e_rs2        <= '0;
      e_funct3     <= '0;
      e_ctrl       <= BUBBLE_CTRL;
      bubble_count <= '0;
    end else if (hold) begin
      e_valid <= e_valid;
    end else if (flush || load_use) begin
      e_valid      <= 1'b0;
      e_pc         <= '0;
      e_rs1_data   <= '0;
      e_rs2_data   <= '0;
      e_imm        <= '0;
      e_opcode     <= '0;
      e_rd         <= '0;
      e_rs1        <= '0;
      e_rs2        <= '0;
      e_funct3     <= '0;
      e_ctrl       <= BUBBLE_CTRL;
      if (bubble_count != CNT_MAX)
        bubble_count <= bubble_count + CNT_ONE;
    end else begin
      e_valid    <= 1'b1;
      e_pc       <= d_pc;
      e_rs1_data <= d_rs1_data;
      e_rs2_data <= d_rs2_data;
      e_imm      <= d_imm;
      e_opcode   <= d_opcode;
      e_rd       <= d_rd;
      e_rs1      <= d_rs1;
      e_rs2      <= d_rs2;
      e_funct3   <= d_funct3;
      e_ctrl     <= d_ctrl;
    end
  end

endmodule
